timer_bus_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the timer IP's 8-bit APB-style register port (TDR/TCR/TSR/TCNT space) between the CPU bus-functional master and a second on-chip master, such as an auto-reload sequencer. It sits between the masters and the timer slave. It serialises whole register transfers, generates the SETUP/ACCESS phases, and returns read data, completion and error status to the granted requester. All outputs are registered.

---
 rtl/timer_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_arbiter.sv
// Two-requester round-robin arbiter for the timer's 8-bit APB-style register port; all outputs registered.
// Define ARB_TIMEOUT_EN to compile in the ACCESS-phase watchdog (TIMEOUT_CYC cycles without pready).
module timer_bus_arbiter #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] rdata0,
   output logic [7:0] rdata1,
   output logic       err0,
   output logic       err1,
   output logic       psel,
   output logic       penable,
   output logic       pwrite,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   input  logic [7:0] prdata,
   input  logic       pready,
   input  logic       pslverr
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;
   logic       owner_q, owner_d;
   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [7:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic [7:0] rdata0_q, rdata0_d;
   logic [7:0] rdata1_q, rdata1_d;
   logic       err0_q, err0_d;
   logic       err1_q, err1_d;
   logic       grant;
   logic       tmo_hit;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SETUP)
         cnt_d = '0;
      else if (state_q == ACCESS && !pready)
         cnt_d = cnt_q + 1'b1;
   end

   // This cycle is the TIMEOUT_CYC-th waiting ACCESS cycle.
   assign tmo_hit = (state_q == ACCESS) && !pready && (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic [15:0] unused_timeout;
   assign unused_timeout = 16'(TIMEOUT_CYC);
   assign tmo_hit = 1'b0;
`endif

   // On a tie the requester not granted last wins.
   always_comb begin
      grant = 1'b0;
      if (req0 && req1) grant = ~last_q;
      else if (req1)    grant = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      err0_d   = err0_q;
      err1_d   = err1_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d  = SETUP;
               owner_d  = grant;
               last_d   = grant;
               pwrite_d = grant ? we1    : we0;
               paddr_d  = grant ? addr1  : addr0;
               pwdata_d = grant ? wdata1 : wdata0;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (pready) begin
               state_d = DONE;
               if (!pwrite_q) begin
                  if (owner_q) rdata1_d = prdata;
                  else         rdata0_d = prdata;
               end
               if (owner_q) err1_d = pslverr;
               else         err0_d = pslverr;
            end else if (tmo_hit) begin
               state_d = DONE;
               if (owner_q) err1_d = 1'b1;
               else         err0_d = 1'b1;
            end
         end
         DONE: begin
            state_d  = IDLE;
            pwrite_d = 1'b0;
            paddr_d  = 8'h00;
            pwdata_d = 8'h00;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus controls and done pulses are registered images of the next state.
   assign psel_d    = (state_d == SETUP) || (state_d == ACCESS);
   assign penable_d = (state_d == ACCESS);
   assign done0_d   = (state_d == DONE) && !owner_d;
   assign done1_d   = (state_d == DONE) && owner_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= 8'h00;
         pwdata_q  <= 8'h00;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         rdata0_q  <= 8'h00;
         rdata1_q  <= 8'h00;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign psel    = psel_q;
   assign penable = penable_q;
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign pwdata  = pwdata_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign err0    = err0_q;
   assign err1    = err1_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: transaction-level model predicts grant order, phase windows and status.
module tb_timer_bus_arbiter;
   localparam int TMO = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] rq, rwe;
   logic [7:0] raddr [2];
   logic [7:0] rwd [2];
   logic       done0, done1, err0, err1, psel, penable, pwrite;
   logic [7:0] rdata0, rdata1, paddr, pwdata, prdata;
   logic       pready, pslverr;

   timer_bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0(rq[0]), .req1(rq[1]), .we0(rwe[0]), .we1(rwe[1]),
      .addr0(raddr[0]), .addr1(raddr[1]), .wdata0(rwd[0]), .wdata1(rwd[1]),
      .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   int n_tests = 0, n_fail = 0, cyc = 0;
   // Reference model: one in-flight transfer described by its SETUP and DONE cycle numbers.
   bit         m_busy, m_owner, m_last, m_we, m_tmo, m_slv;
   logic [7:0] m_addr, m_wd, m_prd;
   int         m_setup, m_done, m_idle;
   logic [7:0] m_rdata [2];
   bit         m_err [2];
   int         left [2];
   bit         rand_mode, tmo_mode;
   int         f_wait, f_rd, f_err;
   int         done_seen [2];
   int         done_q [$];

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_last = 1; m_idle = cyc;
      m_rdata = '{8'h00, 8'h00}; m_err = '{0, 0};
   endtask

   task automatic new_fields(int r);
      rwe[r] = 1'($urandom_range(0, 1));
      raddr[r] = 8'($urandom);
      rwd[r] = 8'($urandom);
   endtask

   task automatic decide();
      int w;
      if (m_busy || rst || cyc < m_idle || !(rq[0] || rq[1])) return;
      if (rq[0] && rq[1]) m_owner = !m_last;
      else                m_owner = rq[1];
      m_last  = m_owner;
      m_we    = rwe[m_owner];
      m_addr  = raddr[m_owner];
      m_wd    = rwd[m_owner];
      w       = (f_wait >= 0) ? f_wait : $urandom_range(0, 4);
      m_prd   = (f_rd >= 0) ? 8'(f_rd) : 8'($urandom);
      m_slv   = (f_err >= 0) ? f_err[0] : ($urandom_range(0, 3) == 0);
      m_tmo   = tmo_mode;
      m_setup = cyc + 1;
      // One SETUP cycle, then w+1 ACCESS cycles (or TMO on watchdog abort), then DONE.
      m_done  = m_tmo ? m_setup + 1 + TMO : m_setup + 2 + w;
      m_busy  = 1;
   endtask

   task automatic check_outputs();
      bit xf, act;
      xf  = m_busy && cyc >= m_setup && cyc <= m_done;
      act = m_busy && cyc >= m_setup && cyc < m_done;
      if (m_busy && cyc == m_done) begin
         if (m_tmo) m_err[m_owner] = 1;
         else begin
            m_err[m_owner] = m_slv;
            if (!m_we) m_rdata[m_owner] = m_prd;
         end
      end
      chk("psel", 8'(psel), 8'(act));
      chk("penable", 8'(penable), 8'(act && cyc > m_setup));
      chk("pwrite", 8'(pwrite), xf ? 8'(m_we) : 8'h00);
      chk("paddr", paddr, xf ? m_addr : 8'h00);
      chk("pwdata", pwdata, xf ? m_wd : 8'h00);
      chk("done0", 8'(done0), 8'(m_busy && cyc == m_done && !m_owner));
      chk("done1", 8'(done1), 8'(m_busy && cyc == m_done && m_owner));
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      if (m_busy && cyc == m_done)
         chk(m_owner ? "err1" : "err0", 8'(m_owner ? err1 : err0), 8'(m_err[m_owner]));
      if (done0) begin done_seen[0]++; done_q.push_back(0); end
      if (done1) begin done_seen[1]++; done_q.push_back(1); end
   endtask

   task automatic drive_slave();
      bit in_acc;
      in_acc = m_busy && cyc >= m_setup + 1 && cyc <= m_done - 1;
      prdata  = 8'($urandom);
      pslverr = 1'($urandom_range(0, 1));
      pready  = in_acc ? 1'b0 : 1'($urandom_range(0, 1));
      if (in_acc && !m_tmo && cyc == m_done - 1) begin
         pready = 1'b1; prdata = m_prd; pslverr = m_slv;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      check_outputs();
      for (int r = 0; r < 2; r++)
         if (m_busy && cyc == m_done && m_owner == r) begin
            if (left[r] > 0) begin
               left[r]--;
               if (rand_mode) new_fields(r);
            end else rq[r] = 1'b0;
         end
      if (m_busy && cyc == m_done) begin
         m_busy = 0; m_idle = cyc + 1;
      end
      if (rand_mode)
         for (int r = 0; r < 2; r++)
            if (!rq[r] && $urandom_range(0, 3) == 0) begin
               new_fields(r); rq[r] = 1'b1; left[r] = $urandom_range(0, 2);
            end
      decide();
      drive_slave();
   endtask

   task automatic raise(int r, bit we, logic [7:0] a, logic [7:0] d, int nleft);
      rwe[r] = we; raddr[r] = a; rwd[r] = d; left[r] = nleft; rq[r] = 1'b1;
   endtask

   task automatic wait_idle(int max);
      int n = 0;
      while ((m_busy || rq != 2'b00) && n < max) begin cycle(); n++; end
      if (n >= max) chk("wait_idle_budget", 8'(1), 8'(0));
   endtask

   initial begin
      rst = 1'b1; rq = 2'b00; rwe = 2'b00;
      raddr = '{8'h00, 8'h00}; rwd = '{8'h00, 8'h00};
      prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
      rand_mode = 0; tmo_mode = 0; f_wait = 0; f_rd = -1; f_err = 0;
      left = '{0, 0}; done_seen = '{0, 0};
      model_reset();
      repeat (2) cycle();
      rst = 1'b0;
      model_reset();

      // Idle after reset: every output stays 0.
      repeat (10) begin
         cycle();
         chk("err0_idle", 8'(err0), 8'h00);
         chk("err1_idle", 8'(err1), 8'h00);
      end

      // Zero-wait write from requester 0.
      raise(0, 1, 8'h02, 8'h03, 0); decide();
      wait_idle(20);

      // Read from requester 1 with 3 wait states.
      f_wait = 3; f_rd = 8'hA5;
      raise(1, 0, 8'h00, 8'h00, 0); decide();
      wait_idle(20);
      chk("rdata1_a5", rdata1, 8'hA5);

      // Simultaneous requests, 3 transfers each: strict alternation.
      f_wait = 0; f_rd = -1;
      done_q.delete(); done_seen = '{0, 0};
      raise(0, 0, 8'h01, 8'h11, 2); raise(1, 1, 8'h03, 8'h22, 2); decide();
      wait_idle(60);
      chk("order_len", 8'(done_q.size()), 8'd6);
      for (int i = 0; i < done_q.size() && i < 6; i++) chk("order", 8'(done_q[i]), 8'(i % 2));
      chk("done0_count", 8'(done_seen[0]), 8'd3);
      chk("done1_count", 8'(done_seen[1]), 8'd3);

      // Slave error on an out-of-range address, then a clean transfer.
      f_err = 1;
      raise(0, 1, 8'hFF, 8'h5A, 0); decide();
      wait_idle(20);
      chk("err0_set", 8'(err0), 8'h01);
      f_err = 0;
      raise(0, 1, 8'h01, 8'h77, 0); decide();
      wait_idle(20);
      chk("err0_clr", 8'(err0), 8'h00);

`ifdef ARB_TIMEOUT_EN
      // Watchdog: pready held low for the whole ACCESS phase.
      tmo_mode = 1;
      raise(0, 0, 8'h02, 8'h00, 0); decide();
      wait_idle(40);
      chk("err0_tmo", 8'(err0), 8'h01);
      tmo_mode = 0;
`endif

      // Random traffic against the model.
      rand_mode = 1; f_wait = -1; f_rd = -1; f_err = -1;
      repeat (3000) cycle();
      rand_mode = 0; left = '{0, 0};
      wait_idle(200);

      // Reset in the middle of a requester-1 ACCESS phase.
      f_wait = 3; f_err = 0;
      raise(1, 0, 8'h01, 8'h00, 0); decide();
      begin
         int n = 0;
         while (!(m_busy && cyc == m_setup + 2) && n < 20) begin cycle(); n++; end
         if (n >= 20) chk("reach_access_budget", 8'(1), 8'(0));
      end
      #2 rst = 1'b1;
      #1;
      chk("psel_async_rst", 8'(psel), 8'h00);
      chk("penable_async_rst", 8'(penable), 8'h00);
      chk("done1_async_rst", 8'(done1), 8'h00);
      rq = 2'b00;
      raise(0, 1, 8'h10, 8'h01, 0); raise(1, 1, 8'h11, 8'h02, 0);
      f_wait = 0;
      model_reset();
      done_q.delete();
      cycle();
      rst = 1'b0;
      m_idle = cyc;
      decide();
      wait_idle(40);
      chk("post_rst_len", 8'(done_q.size()), 8'd2);
      if (done_q.size() > 0) chk("post_rst_first", 8'(done_q[0]), 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
